// File: rtl/framebuffer_arbiter.sv
// Round-robin arbiter sharing the framebuffer RGB and palette ports between
// spi_gpu (requester 0) and the fill/blit engine (requester 1).
module framebuffer_arbiter #(
  parameter int FB_DEPTH     = 76800,
  parameter int READ_LATENCY = 2,
  parameter bit PAL_VBLANK   = 1'b1
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        vblank,

  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic        r0_palette,
  input  logic        r0_write,
  input  logic [16:0] r0_addr,
  input  logic [23:0] r0_wdata,
  output logic        r0_rvalid,
  output logic [23:0] r0_rdata,

  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic        r1_palette,
  input  logic        r1_write,
  input  logic [16:0] r1_addr,
  input  logic [23:0] r1_wdata,
  output logic        r1_rvalid,
  output logic [23:0] r1_rdata,

  output logic [16:0] fb_rgb_addr,
  output logic [7:0]  fb_rgb_in,
  output logic        fb_wren_rgb,
  input  logic [7:0]  fb_rgb_out,
  output logic [7:0]  fb_palette_addr,
  output logic [23:0] fb_palette_in,
  output logic        fb_wren_palette,
  input  logic [23:0] fb_palette_out
);

  typedef struct packed {
    logic valid;
    logic id;
    logic palette;
    logic oor;
  } read_tag_t;

  localparam logic [17:0] FB_LIMIT = 18'(FB_DEPTH);

  logic        elig0;
  logic        elig1;
  logic        last_grant;
  logic        accept;
  logic        sel_palette;
  logic        sel_write;
  logic        sel_oor;
  logic [16:0] sel_addr;
  logic [23:0] sel_wdata;

  read_tag_t   issue_tag;
  read_tag_t   retire_tag;
  read_tag_t   tag_pipe [READ_LATENCY];
  logic [23:0] ret_data;

  // A palette write outside vblank drops out of the contest, so it never stalls the other side.
  always_comb begin
    elig0       = r0_valid && !(PAL_VBLANK && r0_palette && r0_write && !vblank);
    elig1       = r1_valid && !(PAL_VBLANK && r1_palette && r1_write && !vblank);
    r0_ready    = !reset && elig0 && (!elig1 || last_grant);
    r1_ready    = !reset && elig1 && (!elig0 || !last_grant);
    accept      = r0_ready || r1_ready;
    sel_palette = r1_ready ? r1_palette : r0_palette;
    sel_write   = r1_ready ? r1_write   : r0_write;
    sel_addr    = r1_ready ? r1_addr    : r0_addr;
    sel_wdata   = r1_ready ? r1_wdata   : r0_wdata;
    sel_oor     = !sel_palette && ({1'b0, sel_addr} >= FB_LIMIT);
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      last_grant      <= 1'b1;
      fb_rgb_addr     <= '0;
      fb_rgb_in       <= '0;
      fb_wren_rgb     <= 1'b0;
      fb_palette_addr <= '0;
      fb_palette_in   <= '0;
      fb_wren_palette <= 1'b0;
      issue_tag       <= '0;
    end else begin
      fb_wren_rgb     <= 1'b0;
      fb_wren_palette <= 1'b0;
      issue_tag       <= '0;
      if (accept) begin
        last_grant        <= r1_ready;
        issue_tag.valid   <= !sel_write;
        issue_tag.id      <= r1_ready;
        issue_tag.palette <= sel_palette;
        issue_tag.oor     <= sel_oor;
        if (sel_palette) begin
          fb_palette_addr <= sel_addr[7:0];
          if (sel_write) begin
            fb_palette_in   <= sel_wdata;
            fb_wren_palette <= 1'b1;
          end
        end else if (!sel_oor) begin
          // Out-of-range RGB accesses never reach the framebuffer address bus.
          fb_rgb_addr <= sel_addr;
          if (sel_write) begin
            fb_rgb_in   <= sel_wdata[7:0];
            fb_wren_rgb <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= issue_tag;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  always_comb begin
    retire_tag = tag_pipe[READ_LATENCY-1];
    ret_data   = '0;
    if (!retire_tag.oor) begin
      ret_data = retire_tag.palette ? fb_palette_out : {16'd0, fb_rgb_out};
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      r0_rvalid <= retire_tag.valid && !retire_tag.id;
      r1_rvalid <= retire_tag.valid && retire_tag.id;
      if (retire_tag.valid && !retire_tag.id) begin
        r0_rdata <= ret_data;
      end
      if (retire_tag.valid && retire_tag.id) begin
        r1_rdata <= ret_data;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Scoreboard bench for framebuffer_arbiter: requests are queued per requester, expected
// framebuffer writes and read returns are queued at acceptance and matched as they appear.
module tb_framebuffer_arbiter;

  localparam int FB_DEPTH     = 76800;
  localparam int RL           = 2;
  localparam bit PAL_VBLANK   = 1'b1;

  typedef struct {
    logic        palette;
    logic        write;
    logic [16:0] addr;
    logic [23:0] wdata;
  } req_t;

  typedef struct {
    int          cyc;
    logic [16:0] addr;
    logic [23:0] data;
  } exp_t;

  logic        clk_pixel;
  logic        reset;
  logic        vblank;
  logic        r0_valid, r0_ready, r0_palette, r0_write, r0_rvalid;
  logic [16:0] r0_addr;
  logic [23:0] r0_wdata, r0_rdata;
  logic        r1_valid, r1_ready, r1_palette, r1_write, r1_rvalid;
  logic [16:0] r1_addr;
  logic [23:0] r1_wdata, r1_rdata;
  logic [16:0] fb_rgb_addr;
  logic [7:0]  fb_rgb_in;
  logic        fb_wren_rgb;
  logic [7:0]  fb_rgb_out;
  logic [7:0]  fb_palette_addr;
  logic [23:0] fb_palette_in;
  logic        fb_wren_palette;
  logic [23:0] fb_palette_out;

  req_t  req_q0 [$];
  req_t  req_q1 [$];
  exp_t  exp_q [4][$];
  string stream_name [4] = '{"rgb_wr", "pal_wr", "r0_rd", "r1_rd"};

  logic [7:0]  shadow_rgb [int];
  logic [23:0] shadow_pal [int];
  bit   [7:0]  model_rgb [FB_DEPTH];
  bit          written_rgb [FB_DEPTH];
  bit   [23:0] model_pal [256];
  bit          written_pal [256];
  logic [7:0]  rgb_d1;
  logic [23:0] pal_d1;

  int   cyc = 0;
  int   n_checks;
  int   n_fails;
  logic reset_next;
  logic vblank_next;
  logic exp_last;

  framebuffer_arbiter #(
    .FB_DEPTH    (FB_DEPTH),
    .READ_LATENCY(RL),
    .PAL_VBLANK  (PAL_VBLANK)
  ) dut (
    .clk_pixel      (clk_pixel),
    .reset          (reset),
    .vblank         (vblank),
    .r0_valid       (r0_valid),
    .r0_ready       (r0_ready),
    .r0_palette     (r0_palette),
    .r0_write       (r0_write),
    .r0_addr        (r0_addr),
    .r0_wdata       (r0_wdata),
    .r0_rvalid      (r0_rvalid),
    .r0_rdata       (r0_rdata),
    .r1_valid       (r1_valid),
    .r1_ready       (r1_ready),
    .r1_palette     (r1_palette),
    .r1_write       (r1_write),
    .r1_addr        (r1_addr),
    .r1_wdata       (r1_wdata),
    .r1_rvalid      (r1_rvalid),
    .r1_rdata       (r1_rdata),
    .fb_rgb_addr    (fb_rgb_addr),
    .fb_rgb_in      (fb_rgb_in),
    .fb_wren_rgb    (fb_wren_rgb),
    .fb_rgb_out     (fb_rgb_out),
    .fb_palette_addr(fb_palette_addr),
    .fb_palette_in  (fb_palette_in),
    .fb_wren_palette(fb_wren_palette),
    .fb_palette_out (fb_palette_out)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  always @(posedge clk_pixel) cyc <= cyc + 1;

  function automatic logic [7:0] init_rgb(input int a);
    return 8'((a * 7 + 3) ^ (a >> 9));
  endfunction

  function automatic logic [23:0] init_pal(input int a);
    return 24'(a * 32'h00010305 + 32'h000A0F00);
  endfunction

  // Framebuffer model with a two-cycle read latency.
  always @(posedge clk_pixel) begin
    if (fb_wren_rgb) begin
      model_rgb[fb_rgb_addr]   <= fb_rgb_in;
      written_rgb[fb_rgb_addr] <= 1'b1;
    end
    if (fb_wren_palette) begin
      model_pal[fb_palette_addr]   <= fb_palette_in;
      written_pal[fb_palette_addr] <= 1'b1;
    end
    rgb_d1 <= written_rgb[fb_rgb_addr] ? model_rgb[fb_rgb_addr] : init_rgb(int'(fb_rgb_addr));
    pal_d1 <= written_pal[fb_palette_addr] ? model_pal[fb_palette_addr]
                                           : init_pal(int'(fb_palette_addr));
    fb_rgb_out     <= rgb_d1;
    fb_palette_out <= pal_d1;
  end

  function automatic logic [7:0] rgb_expect(input int a);
    return shadow_rgb.exists(a) ? shadow_rgb[a] : init_rgb(a);
  endfunction

  function automatic logic [23:0] pal_expect(input int a);
    return shadow_pal.exists(a) ? shadow_pal[a] : init_pal(a);
  endfunction

  function automatic int pending();
    int n;
    n = req_q0.size() + req_q1.size();
    for (int s = 0; s < 4; s++) n += exp_q[s].size();
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, actual, expected);
    end
  endtask

  task automatic push_req(input int id, input logic pal, input logic wr,
                          input logic [16:0] addr, input logic [23:0] wdata);
    req_t r;
    r.palette = pal;
    r.write   = wr;
    r.addr    = addr;
    r.wdata   = wdata;
    if (id == 0) req_q0.push_back(r);
    else         req_q1.push_back(r);
  endtask

  task automatic accept_request(input int id, input req_t r);
    exp_t e;
    int   a;
    exp_last = (id == 1);
    e.addr   = '0;
    e.data   = '0;
    if (r.palette) begin
      a = int'(r.addr[7:0]);
      if (r.write) begin
        shadow_pal[a] = r.wdata;
        e.cyc  = cyc + 1;
        e.addr = 17'(a);
        e.data = r.wdata;
        exp_q[1].push_back(e);
      end else begin
        e.cyc  = cyc + 2 + RL;
        e.data = pal_expect(a);
        exp_q[2 + id].push_back(e);
      end
    end else begin
      a = int'(r.addr);
      if (r.write) begin
        if (a < FB_DEPTH) begin
          shadow_rgb[a] = r.wdata[7:0];
          e.cyc  = cyc + 1;
          e.addr = r.addr;
          e.data = {16'd0, r.wdata[7:0]};
          exp_q[0].push_back(e);
        end
      end else begin
        e.cyc  = cyc + 2 + RL;
        e.data = (a < FB_DEPTH) ? {16'd0, rgb_expect(a)} : 24'd0;
        exp_q[2 + id].push_back(e);
      end
    end
  endtask

  task automatic monitor_outputs();
    logic [3:0]  pulse;
    logic [16:0] oaddr [4];
    logic [23:0] odata [4];
    exp_t        e;
    pulse    = {r1_rvalid, r0_rvalid, fb_wren_palette, fb_wren_rgb};
    oaddr[0] = fb_rgb_addr;
    oaddr[1] = {9'd0, fb_palette_addr};
    oaddr[2] = '0;
    oaddr[3] = '0;
    odata[0] = {16'd0, fb_rgb_in};
    odata[1] = fb_palette_in;
    odata[2] = r0_rdata;
    odata[3] = r1_rdata;
    if (reset) begin
      checkOutput("reset_outputs",
                  128'({r0_ready, r1_ready, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
                        fb_rgb_addr, fb_rgb_in, fb_wren_rgb, fb_palette_addr,
                        fb_palette_in, fb_wren_palette}), 128'(0));
    end
    for (int s = 0; s < 4; s++) begin
      if (pulse[s]) begin
        if (exp_q[s].size() == 0) begin
          checkOutput({stream_name[s], "_spurious"}, 128'(pulse[s]), 128'(0));
        end else begin
          e = exp_q[s].pop_front();
          checkOutput({stream_name[s], "_cycle"}, 128'(cyc), 128'(e.cyc));
          checkOutput({stream_name[s], "_data"}, 128'(odata[s]), 128'(e.data));
          if (s < 2) checkOutput({stream_name[s], "_addr"}, 128'(oaddr[s]), 128'(e.addr));
        end
      end else if (exp_q[s].size() > 0) begin
        if (exp_q[s][0].cyc <= cyc) begin
          checkOutput({stream_name[s], "_missing"}, 128'(pulse[s]), 128'(1));
          void'(exp_q[s].pop_front());
        end
      end
    end
  endtask

  task automatic drive_requests();
    r0_valid = 1'b0; r0_palette = 1'b0; r0_write = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_valid = 1'b0; r1_palette = 1'b0; r1_write = 1'b0; r1_addr = '0; r1_wdata = '0;
    if (req_q0.size() > 0) begin
      r0_valid   = 1'b1;
      r0_palette = req_q0[0].palette;
      r0_write   = req_q0[0].write;
      r0_addr    = req_q0[0].addr;
      r0_wdata   = req_q0[0].wdata;
    end
    if (req_q1.size() > 0) begin
      r1_valid   = 1'b1;
      r1_palette = req_q1[0].palette;
      r1_write   = req_q1[0].write;
      r1_addr    = req_q1[0].addr;
      r1_wdata   = req_q1[0].wdata;
    end
  endtask

  // Reference arbitration: eligible requesters contend, ties go to the one not granted last.
  task automatic arbitrate_and_check();
    logic e0, e1, x0, x1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (req_q0.size() > 0)
      e0 = !(PAL_VBLANK && req_q0[0].palette && req_q0[0].write && !vblank);
    if (req_q1.size() > 0)
      e1 = !(PAL_VBLANK && req_q1[0].palette && req_q1[0].write && !vblank);
    if (reset) begin
      x0 = 1'b0;
      x1 = 1'b0;
    end else if (e0 && e1) begin
      x0 = exp_last;
      x1 = !exp_last;
    end else begin
      x0 = e0;
      x1 = e1;
    end
    checkOutput("r0_ready", 128'(r0_ready), 128'(x0));
    checkOutput("r1_ready", 128'(r1_ready), 128'(x1));
    if (x0)      accept_request(0, req_q0.pop_front());
    else if (x1) accept_request(1, req_q1.pop_front());
  endtask

  task automatic step_cycle();
    @(negedge clk_pixel);
    monitor_outputs();
    reset  = reset_next;
    vblank = vblank_next;
    if (reset) begin
      for (int s = 0; s < 4; s++) exp_q[s].delete();
      exp_last = 1'b1;
    end
    drive_requests();
    #1;
    arbitrate_and_check();
  endtask

  task automatic applyStimulus(input int budget);
    int n;
    n = 0;
    while (pending() > 0 && n < budget) begin
      step_cycle();
      n++;
    end
    checkOutput("drain_pending", 128'(pending()), 128'(0));
  endtask

  task automatic do_reset();
    reset_next = 1'b1;
    repeat (2) step_cycle();
    reset_next = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    reset       = 1'b1;
    reset_next  = 1'b1;
    vblank      = 1'b0;
    vblank_next = 1'b0;
    exp_last    = 1'b1;
    drive_requests();
    $display("[TB] framebuffer_arbiter scoreboard bench");

    repeat (3) step_cycle();
    reset_next = 1'b0;

    push_req(0, 1'b0, 1'b1, 17'h00100, 24'h00005A);
    applyStimulus(20);

    do_reset();
    for (int i = 0; i < 2; i++) begin
      push_req(0, 1'b0, 1'b1, 17'(32'h200 + i), 24'(32'h10 + i));
      push_req(1, 1'b0, 1'b1, 17'(32'h300 + i), 24'(32'h20 + i));
    end
    applyStimulus(20);

    vblank_next = 1'b0;
    push_req(1, 1'b1, 1'b1, 17'd7, 24'h123456);
    for (int i = 0; i < 6; i++) push_req(0, 1'b0, 1'b0, 17'(32'h100 + i), 24'd0);
    repeat (4) step_cycle();
    vblank_next = 1'b1;
    applyStimulus(30);
    push_req(1, 1'b1, 1'b0, 17'd7, 24'd0);
    push_req(0, 1'b1, 1'b0, 17'h10008, 24'd0);
    applyStimulus(30);

    push_req(1, 1'b1, 1'b1, 17'd9, 24'hABCDEF);
    for (int i = 0; i < 3; i++) push_req(0, 1'b0, 1'b1, 17'(32'h400 + i), 24'(i + 1));
    step_cycle();
    vblank_next = 1'b0;
    repeat (3) step_cycle();
    vblank_next = 1'b1;
    applyStimulus(30);
    push_req(1, 1'b1, 1'b0, 17'd9, 24'd0);
    applyStimulus(30);

    do_reset();
    push_req(0, 1'b0, 1'b0, 17'h00010, 24'd0);
    push_req(0, 1'b0, 1'b0, 17'h00011, 24'd0);
    push_req(0, 1'b0, 1'b0, 17'h00100, 24'd0);
    applyStimulus(30);

    push_req(1, 1'b0, 1'b1, 17'd76800, 24'h0000EE);
    push_req(1, 1'b0, 1'b0, 17'd76800, 24'd0);
    push_req(1, 1'b0, 1'b1, 17'd76799, 24'h000077);
    push_req(1, 1'b0, 1'b0, 17'd76799, 24'd0);
    applyStimulus(30);

    push_req(0, 1'b0, 1'b0, 17'h00200, 24'd0);
    step_cycle();
    reset_next = 1'b1;
    repeat (3) step_cycle();
    reset_next = 1'b0;
    push_req(0, 1'b0, 1'b0, 17'h00201, 24'd0);
    push_req(1, 1'b0, 1'b0, 17'h00301, 24'd0);
    applyStimulus(30);

    repeat (6) step_cycle();
    checkOutput("final_drain", 128'(pending()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
